// File: rtl/esm_buffer_writer.sv
// esm_buffer_writer: writer side of the ESM instruction buffer.
// Accepts decoded instructions over a valid/ready handshake, allocates the lowest free slot,
// drives a registered write port and reclaims slots reported as issued.
// Optional feature: define ESM_BUFFER_WRITER_ERR_EN to enable the sticky invalid-free error flag;
// when undefined, err is tied low and invalid frees are silently ignored.
module esm_buffer_writer #(
  parameter int unsigned Instr_word_size = 32,
  parameter int unsigned bs              = 16,
  localparam int unsigned bs_bits        = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Instr_word_size-1:0] Instr_in,
  input  logic                       ALUSrc_in,
  input  logic                       RegWrite_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       issue_valid,
  input  logic [bs_bits-1:0]         issue_index,
  output logic                       wr_en,
  output logic [bs_bits-1:0]         wr_index,
  output logic [Instr_word_size-1:0] Instr_out,
  output logic                       ALUSrc_out,
  output logic                       RegWrite_out,
  output logic [bs_bits:0]           occupancy,
  output logic                       full,
  output logic                       empty,
  output logic                       start,
  output logic                       err
);

  localparam logic [bs_bits:0] BsCount = (bs_bits + 1)'(bs);

  logic [bs-1:0]              r_occ_mask;
  logic [bs_bits:0]           r_occupancy;
  logic                       r_full;
  logic                       r_empty;
  logic                       r_wr_en;
  logic [bs_bits-1:0]         r_wr_index;
  logic [Instr_word_size-1:0] r_instr;
  logic                       r_alu_src;
  logic                       r_reg_write;
  logic                       r_start;

  logic                       w_accept;
  logic                       w_free_ok;
  logic [bs_bits-1:0]         w_alloc_idx;
  logic [bs-1:0]              w_mask_d;
  logic [bs_bits:0]           w_occ_d;

  // Ready depends only on registered state, never on same-cycle inputs.
  assign w_accept  = in_valid & ~r_full;
  assign w_free_ok = issue_valid & r_occ_mask[issue_index];

  // Priority encoder: lowest-index free slot of the registered mask (same-cycle frees unseen).
  always_comb begin
    w_alloc_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!r_occ_mask[i]) begin
        w_alloc_idx = bs_bits'(i);
      end
    end
  end

  // Next mask and occupancy; alloc and a valid free can never hit the same slot.
  always_comb begin
    w_mask_d = r_occ_mask;
    w_occ_d  = r_occupancy;
    if (w_accept) begin
      w_mask_d[w_alloc_idx] = 1'b1;
    end
    if (w_free_ok) begin
      w_mask_d[issue_index] = 1'b0;
    end
    unique case ({w_accept, w_free_ok})
      2'b10:   w_occ_d = r_occupancy + 1'b1;
      2'b01:   w_occ_d = r_occupancy - 1'b1;
      default: w_occ_d = r_occupancy;
    endcase
  end

  // Slot tracking, registered write port and the empty->non-empty start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ_mask  <= '0;
      r_occupancy <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_wr_en     <= 1'b0;
      r_wr_index  <= '0;
      r_instr     <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      r_occ_mask  <= w_mask_d;
      r_occupancy <= w_occ_d;
      r_full      <= (w_occ_d == BsCount);
      r_empty     <= (w_occ_d == '0);
      r_wr_en     <= w_accept;
      r_start     <= w_accept & (r_occupancy == '0);
      if (w_accept) begin
        r_wr_index  <= w_alloc_idx;
        r_instr     <= Instr_in;
        r_alu_src   <= ALUSrc_in;
        r_reg_write <= RegWrite_in;
      end
    end
  end

`ifdef ESM_BUFFER_WRITER_ERR_EN
  logic r_err;

  // Sticky flag for a free that targets an unoccupied slot; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (issue_valid & ~r_occ_mask[issue_index]) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready     = ~r_full;
  assign wr_en        = r_wr_en;
  assign wr_index     = r_wr_index;
  assign Instr_out    = r_instr;
  assign ALUSrc_out   = r_alu_src;
  assign RegWrite_out = r_reg_write;
  assign occupancy    = r_occupancy;
  assign full         = r_full;
  assign empty        = r_empty;
  assign start        = r_start;

endmodule
